vdp_super_palette: RTL

256-entry, 24-bit RGB palette RAM feeding the super-resolution pixel path. The display side presents an 8-bit palette index every clk and receives registered 8-bit R/G/B one cycle later. The CPU side loads entries through a byte-serial R→G→B port with an auto-incrementing index. After reset, an internal sequencer fills the table with a default grey ramp before CPU writes are accepted.

---
 rtl/vdp_super_palette_if.sv | 33 +++
 rtl/vdp_super_palette.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/vdp_super_palette_if.sv
// Display and CPU-side bus of the super-resolution palette.
// cpu_rd_data exists only when VDP_SUPER_PALETTE_READBACK_EN is defined.
interface vdp_super_palette_if;
   logic [7:0] palette_addr;
   logic [7:0] palette_r;
   logic [7:0] palette_g;
   logic [7:0] palette_b;
   logic       cpu_index_wr;
   logic       cpu_data_wr;
   logic [7:0] cpu_data;
   logic       busy;
`ifdef VDP_SUPER_PALETTE_READBACK_EN
   logic [7:0] cpu_rd_data;

   modport master (
      output palette_addr, cpu_index_wr, cpu_data_wr, cpu_data,
      input  palette_r, palette_g, palette_b, busy, cpu_rd_data
   );
   modport slave (
      input  palette_addr, cpu_index_wr, cpu_data_wr, cpu_data,
      output palette_r, palette_g, palette_b, busy, cpu_rd_data
   );
`else
   modport master (
      output palette_addr, cpu_index_wr, cpu_data_wr, cpu_data,
      input  palette_r, palette_g, palette_b, busy
   );
   modport slave (
      input  palette_addr, cpu_index_wr, cpu_data_wr, cpu_data,
      output palette_r, palette_g, palette_b, busy
   );
`endif
endinterface

// File: rtl/vdp_super_palette.sv
// 256 x 24-bit palette RAM: registered display read port, byte-serial CPU
// write port with auto-increment, and a default grey-ramp fill after reset.
// Optional feature macro: VDP_SUPER_PALETTE_READBACK_EN (CPU read-back).
module vdp_super_palette #(
   parameter bit INIT_ON_RESET = 1'b1
) (
   input logic                 clk,
   input logic                 reset,
   vdp_super_palette_if.slave  bus
);
   localparam int unsigned AW    = 8;
   localparam int unsigned DW    = 24;
   localparam int unsigned DEPTH = 256;

   typedef enum logic [1:0] {PH_R, PH_G, PH_B, FILL} state_t;

   logic [DW-1:0] mem [DEPTH];
   state_t        state;
   logic [AW-1:0] wr_index;
   logic [AW-1:0] fill_cnt;
   logic [7:0]    red;
   logic [7:0]    green;

   logic          wr_en_c;
   logic [AW-1:0] wr_addr_c;
   logic [DW-1:0] wr_data_c;

`ifdef VDP_SUPER_PALETTE_READBACK_EN
   logic          rd_mode;
   logic          rd_fetch_c;
   logic [AW-1:0] rd_addr_c;
   logic [DW-1:0] rd_hold;
`endif

   // Port B write source: fill sequencer in FILL, otherwise the B-phase commit
   always_comb begin
      wr_en_c   = 1'b0;
      wr_addr_c = wr_index;
      wr_data_c = {red, green, bus.cpu_data};
      if (state == FILL) begin
         wr_en_c   = 1'b1;
         wr_addr_c = fill_cnt;
         wr_data_c = {fill_cnt, fill_cnt, fill_cnt};
      end else if (state == PH_B && bus.cpu_data_wr && !bus.cpu_index_wr) begin
`ifdef VDP_SUPER_PALETTE_READBACK_EN
         wr_en_c = !rd_mode;
`else
         wr_en_c = 1'b1;
`endif
      end
   end

   // Port B write; no reset on the array itself
   always_ff @(posedge clk) begin
      if (wr_en_c) mem[wr_addr_c] <= wr_data_c;
   end

   // Port A display read, read-first against a same-cycle port B write
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bus.palette_r <= 8'd0;
         bus.palette_g <= 8'd0;
         bus.palette_b <= 8'd0;
      end else begin
         {bus.palette_r, bus.palette_g, bus.palette_b} <= mem[bus.palette_addr];
      end
   end

   // Fill sequencer and CPU byte-phase FSM
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= INIT_ON_RESET ? FILL : PH_R;
         bus.busy <= INIT_ON_RESET;
         wr_index <= '0;
         fill_cnt <= '0;
         red      <= 8'd0;
         green    <= 8'd0;
`ifdef VDP_SUPER_PALETTE_READBACK_EN
         rd_mode  <= 1'b0;
`endif
      end else if (state == FILL) begin
         fill_cnt <= AW'(fill_cnt + 1'b1);
         if (fill_cnt == AW'(DEPTH - 1)) begin
            state    <= PH_R;
            bus.busy <= 1'b0;
            wr_index <= '0;
         end
      end else if (bus.cpu_index_wr) begin
         state <= PH_R;
         red   <= 8'd0;
         green <= 8'd0;
`ifdef VDP_SUPER_PALETTE_READBACK_EN
         rd_mode  <= bus.cpu_data[7];
         wr_index <= bus.cpu_data[7] ? {1'b0, bus.cpu_data[6:0]} : bus.cpu_data;
`else
         wr_index <= bus.cpu_data;
`endif
      end else if (bus.cpu_data_wr) begin
         case (state)
            PH_R: begin
               red   <= bus.cpu_data;
               state <= PH_G;
            end
            PH_G: begin
               green <= bus.cpu_data;
               state <= PH_B;
            end
            PH_B: begin
               wr_index <= AW'(wr_index + 1'b1);
               state    <= PH_R;
            end
            default: state <= PH_R;
         endcase
      end
   end

`ifdef VDP_SUPER_PALETTE_READBACK_EN
   // Read-back fetch: on an index load, or on the B strobe of a read triplet
   always_comb begin
      rd_fetch_c = 1'b0;
      rd_addr_c  = AW'(wr_index + 1'b1);
      if (state != FILL) begin
         if (bus.cpu_index_wr) begin
            rd_fetch_c = 1'b1;
            rd_addr_c  = bus.cpu_data[7] ? {1'b0, bus.cpu_data[6:0]} : bus.cpu_data;
         end else if (bus.cpu_data_wr && rd_mode && state == PH_B) begin
            rd_fetch_c = 1'b1;
         end
      end
   end

   // Holding register for the fetched entry
   always_ff @(posedge clk or posedge reset) begin
      if (reset)           rd_hold <= '0;
      else if (rd_fetch_c) rd_hold <= mem[rd_addr_c];
   end

   // Byte of the holding register selected by the current phase
   always_comb begin
      bus.cpu_rd_data = 8'd0;
      case (state)
         PH_R:    bus.cpu_rd_data = rd_hold[23:16];
         PH_G:    bus.cpu_rd_data = rd_hold[15:8];
         PH_B:    bus.cpu_rd_data = rd_hold[7:0];
         default: bus.cpu_rd_data = 8'd0;
      endcase
   end
`endif

endmodule
